periph_sram_packer: RTL and testbench

Peripheral-to-SRAM write stage of the SoC DMA path. Accepts a byte stream from the SPI/I2C peripheral side over a valid/ready handshake. Packs the bytes little-endian into 32-bit words and issues word writes to the on-chip SRAM port at incrementing addresses. One programmed transfer runs per `start` pulse and is closed with a `done` pulse; a trailing partial word is flushed with byte enables.

---
 rtl/soc_dma_pkg.sv | 27 ++
 rtl/periph_sram_packer_byte_lane_packer.sv | 82 ++++++++
 rtl/periph_sram_packer.sv | 136 +++++++++++++
 tb/tb_periph_sram_packer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_dma_pkg.sv
// Shared definitions for the SoC DMA path.
// Contents:
//   WORD_W, LANES - SRAM word width and byte-lane count
//   dma_state_t   - FSM state encoding of the peripheral-to-SRAM packer
//   lanes_to_be   - byte-enable mask for the first n lanes (n = 0..4)
package soc_dma_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANES  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } dma_state_t;

  function automatic logic [LANES-1:0] lanes_to_be(input logic [2:0] n);
    logic [LANES-1:0] be;
    be = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (i < 32'(n)) be[i] = 1'b1;
    end
    return be;
  endfunction

endpackage

// File: rtl/periph_sram_packer_byte_lane_packer.sv
// byte_lane_packer: assembles accepted bytes little-endian into a 32-bit
// word and holds a complete word while the downstream register is busy.
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   clear       - empty the packer (new transfer)
//   accept      - byte_in is taken this cycle
//   byte_in     - incoming byte
//   last        - the accepted byte is the final byte of the transfer
//   out_free    - output register can load a word at this edge
//   word_valid  - a complete word is offered (stalled or just completed)
//   word_data   - offered word, unwritten lanes zero
//   word_be     - byte enables for the offered word
//   stalled     - a complete word is parked in the pack register
module byte_lane_packer
  import soc_dma_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        byte_in,
  input  logic              last,
  input  logic              out_free,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data,
  output logic [LANES-1:0]  word_be,
  output logic              stalled
);

  logic [WORD_W-1:0] pack_data;
  logic [LANES-1:0]  stall_be;
  logic [1:0]        lane_idx;
  logic [WORD_W-1:0] asm_data;
  logic [LANES-1:0]  asm_be;
  logic              complete;

  // The word including the byte being accepted this cycle; a completing
  // byte bypasses the pack register so a word can leave on the same edge.
  always_comb begin
    asm_data = pack_data;
    asm_data[{lane_idx, 3'b000} +: 8] = byte_in;
    asm_be   = lanes_to_be({1'b0, lane_idx} + 3'd1);
    complete = accept && ((lane_idx == 2'd3) || last);
    if (stalled) begin
      word_valid = 1'b1;
      word_data  = pack_data;
      word_be    = stall_be;
    end else begin
      word_valid = complete;
      word_data  = asm_data;
      word_be    = asm_be;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pack_data <= '0;
      stall_be  <= '0;
      lane_idx  <= '0;
      stalled   <= 1'b0;
    end else if (stalled) begin
      if (out_free) begin
        stalled   <= 1'b0;
        pack_data <= '0;
      end
    end else if (accept) begin
      lane_idx <= lane_idx + 2'd1;
      if (complete) begin
        if (out_free) begin
          pack_data <= '0;
        end else begin
          pack_data <= asm_data;
          stall_be  <= asm_be;
          stalled   <= 1'b1;
        end
      end else begin
        pack_data <= asm_data;
      end
    end
  end

endmodule

// File: rtl/periph_sram_packer.sv
// periph_sram_packer: takes a byte stream from a peripheral (valid/ready),
// packs it little-endian into 32-bit words and writes them to SRAM at
// incrementing word addresses. One transfer per start pulse, ended by done.
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   start, base_addr,
//   byte_count            - transfer command, sampled in IDLE
//   busy, done            - transfer in progress / one-cycle completion pulse
//   peripheral_data_in,
//   periph_valid,
//   periph_ready          - byte stream input handshake
//   mem_req, memory_address, memory_data_out, mem_be,
//   memory_write_enable,
//   mem_gnt               - SRAM write port
module periph_sram_packer
  import soc_dma_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic [LEN_W-1:0]  byte_count,
  output logic              busy,
  output logic              done,
  input  logic [7:0]        peripheral_data_in,
  input  logic              periph_valid,
  output logic              periph_ready,
  output logic              mem_req,
  output logic [31:0]       memory_address,
  output logic [WORD_W-1:0] memory_data_out,
  output logic [LANES-1:0]  mem_be,
  output logic              memory_write_enable,
  input  logic              mem_gnt
);

  dma_state_t        state;
  logic [LEN_W-1:0]  bytes_left;
  logic              out_valid;
  logic              accept;
  logic              out_free;
  logic              grant;
  logic              load;
  logic              clear;
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic [LANES-1:0]  word_be;
  logic              stalled;

  assign periph_ready        = (state == ST_RUN) && (bytes_left != '0) && !stalled;
  assign accept              = periph_valid && periph_ready;
  assign grant               = out_valid && mem_gnt;
  assign out_free            = !out_valid || mem_gnt;
  assign load                = word_valid && out_free;
  assign clear               = (state == ST_IDLE) && start;
  assign mem_req             = out_valid;
  assign memory_write_enable = out_valid;

  byte_lane_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .accept     (accept),
    .byte_in    (peripheral_data_in),
    .last       (bytes_left == LEN_W'(1)),
    .out_free   (out_free),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_be    (word_be),
    .stalled    (stalled)
  );

  // memory_address is the address counter itself: it always names the word
  // sitting in (or next entering) the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      bytes_left      <= '0;
      out_valid       <= 1'b0;
      memory_address  <= '0;
      memory_data_out <= '0;
      mem_be          <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      if (grant) memory_address <= memory_address + 32'd4;

      if (load) begin
        out_valid       <= 1'b1;
        memory_data_out <= word_data;
        mem_be          <= word_be;
      end else if (grant) begin
        out_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            memory_address <= base_addr & ~32'h3;
            bytes_left     <= byte_count;
            if (byte_count == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            bytes_left <= bytes_left - LEN_W'(1);
            if (bytes_left == LEN_W'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Finish on the edge that empties the last buffered word so done
          // lands in the cycle right after the final grant.
          if (!stalled && out_free) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_sram_packer.sv
// Directed self-checking bench for periph_sram_packer.
module tb_periph_sram_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] byte_count;
  logic        busy;
  logic        done;
  logic [7:0]  peripheral_data_in;
  logic        periph_valid;
  logic        periph_ready;
  logic        mem_req;
  logic [31:0] memory_address;
  logic [31:0] memory_data_out;
  logic [3:0]  mem_be;
  logic        memory_write_enable;
  logic        mem_gnt;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  src [16];
  logic [31:0] wr_addr [8];
  logic [31:0] wr_data [8];
  logic [3:0]  wr_be [8];
  int n_wr, gap, block_sent, hold_err, we_err;
  bit got_done, busy_first, busy_at_done, req_seen;

  always #5 clk = ~clk;

  periph_sram_packer #(.LEN_W(16)) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .base_addr           (base_addr),
    .byte_count          (byte_count),
    .busy                (busy),
    .done                (done),
    .peripheral_data_in  (peripheral_data_in),
    .periph_valid        (periph_valid),
    .periph_ready        (periph_ready),
    .mem_req             (mem_req),
    .memory_address      (memory_address),
    .memory_data_out     (memory_data_out),
    .mem_be              (mem_be),
    .memory_write_enable (memory_write_enable),
    .mem_gnt             (mem_gnt)
  );

  // Drives one transfer at negedges and records every granted write.
  // stall_cycles>0 holds mem_gnt low that many cycles from the first mem_req.
  // restart_cyc>=0 pulses start with another command mid-transfer.
  task automatic run_xfer(input logic [31:0] base, input int count,
                          input int stall_cycles, input int restart_cyc);
    int sent, stall_left, last_g;
    bit stall_armed, pend;
    logic [31:0] ha, hd;
    logic [3:0]  hb;
    sent = 0; stall_left = 0; stall_armed = (stall_cycles > 0); pend = 0; last_g = -100;
    ha = '0; hd = '0; hb = '0;
    n_wr = 0; got_done = 0; gap = -1; busy_first = 0; busy_at_done = 1;
    block_sent = -1; hold_err = 0; we_err = 0; req_seen = 0;
    for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
      @(negedge clk);
      start = (cyc == 0) || (cyc == restart_cyc);
      if (cyc == 0) begin base_addr = base; byte_count = 16'(count); end
      if (cyc == restart_cyc) begin base_addr = 32'hDEAD_0000; byte_count = 16'd3; end
      if (cyc == 1) busy_first = busy;
      if (done) begin got_done = 1; gap = cyc - last_g; busy_at_done = busy; end
      if (memory_write_enable !== mem_req) we_err++;
      if (mem_req) req_seen = 1;
      if (pend && mem_req && ({memory_address, memory_data_out, mem_be} !== {ha, hd, hb}))
        hold_err++;
      if (mem_req && stall_armed) begin stall_left = stall_cycles; stall_armed = 0; end
      mem_gnt = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (mem_req && mem_gnt) begin
        if (n_wr < 8) begin
          wr_addr[n_wr] = memory_address;
          wr_data[n_wr] = memory_data_out;
          wr_be[n_wr]   = mem_be;
        end
        n_wr++;
        last_g = cyc;
      end
      pend = mem_req && !mem_gnt;
      ha = memory_address; hd = memory_data_out; hb = mem_be;
      if (cyc > 0 && busy && sent < count && !periph_ready && block_sent < 0) block_sent = sent;
      periph_valid = (cyc > 0) && (sent < count);
      peripheral_data_in = periph_valid ? src[sent] : 8'h00;
      if (periph_valid && periph_ready) sent++;
    end
    @(negedge clk);
    start = 0; periph_valid = 0; mem_gnt = 0;
  endtask

  task automatic test_reset;
    reset = 1; start = 0; base_addr = '0; byte_count = '0;
    periph_valid = 0; peripheral_data_in = '0; mem_gnt = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, periph_ready, mem_req, memory_write_enable} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=00000",
               {busy, done, periph_ready, mem_req, memory_write_enable});
    end
    checks++;
    if ({memory_address, memory_data_out, mem_be} !== 68'h0) begin
      failures++;
      $display("FAIL reset_bus got addr=%h data=%h be=%h want all 0",
               memory_address, memory_data_out, mem_be);
    end
    reset = 0;
  endtask

  task automatic test_streaming;
    logic [31:0] ea [2];
    logic [31:0] ed [2];
    ea = '{32'h100, 32'h104};
    ed = '{32'h4433_2211, 32'h8877_6655};
    for (int i = 0; i < 8; i++) src[i] = 8'(8'h11 * (i + 1));
    run_xfer(32'h100, 8, 0, -1);
    checks++;
    if (!got_done || n_wr != 2) begin
      failures++;
      $display("FAIL stream_count got done=%0d writes=%0d want done=1 writes=2", got_done, n_wr);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (wr_addr[i] !== ea[i] || wr_data[i] !== ed[i] || wr_be[i] !== 4'hF) begin
        failures++;
        $display("FAIL stream_w%0d got %h<-%h be %h want %h<-%h be f",
                 i, wr_addr[i], wr_data[i], wr_be[i], ea[i], ed[i]);
      end
    end
    checks++;
    if (gap != 1) begin
      failures++;
      $display("FAIL stream_done_gap got=%0d want=1", gap);
    end
    checks++;
    if (busy_first !== 1'b1 || busy_at_done !== 1'b0) begin
      failures++;
      $display("FAIL stream_busy got first=%0d at_done=%0d want 1 0", busy_first, busy_at_done);
    end
    checks++;
    if (we_err != 0 || block_sent != -1) begin
      failures++;
      $display("FAIL stream_flow got we_err=%0d block_at=%0d want 0 -1", we_err, block_sent);
    end
  endtask

  task automatic test_partial;
    for (int i = 0; i < 5; i++) src[i] = 8'(8'hA1 + i);
    run_xfer(32'h203, 5, 0, -1);
    checks++;
    if (!got_done || n_wr != 2) begin
      failures++;
      $display("FAIL partial_count got done=%0d writes=%0d want 1 2", got_done, n_wr);
    end
    checks++;
    if (wr_addr[0] !== 32'h200 || wr_data[0] !== 32'hA4A3_A2A1 || wr_be[0] !== 4'hF) begin
      failures++;
      $display("FAIL partial_w0 got %h<-%h be %h want 00000200<-a4a3a2a1 be f",
               wr_addr[0], wr_data[0], wr_be[0]);
    end
    checks++;
    if (wr_addr[1] !== 32'h204 || wr_data[1] !== 32'h0000_00A5 || wr_be[1] !== 4'h1) begin
      failures++;
      $display("FAIL partial_w1 got %h<-%h be %h want 00000204<-000000a5 be 1",
               wr_addr[1], wr_data[1], wr_be[1]);
    end
  endtask

  task automatic test_grant_stall;
    logic [31:0] ed [3];
    ed = '{32'h0403_0201, 32'h0807_0605, 32'h0C0B_0A09};
    for (int i = 0; i < 12; i++) src[i] = 8'(i + 1);
    run_xfer(32'h1000, 12, 10, -1);
    checks++;
    if (block_sent != 8) begin
      failures++;
      $display("FAIL stall_backpressure got bytes_before_block=%0d want=8", block_sent);
    end
    checks++;
    if (hold_err != 0) begin
      failures++;
      $display("FAIL stall_hold got changes=%0d want=0", hold_err);
    end
    checks++;
    if (!got_done || n_wr != 3) begin
      failures++;
      $display("FAIL stall_count got done=%0d writes=%0d want 1 3", got_done, n_wr);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_addr[i] !== 32'h1000 + 32'(4 * i) || wr_data[i] !== ed[i] || wr_be[i] !== 4'hF) begin
        failures++;
        $display("FAIL stall_w%0d got %h<-%h be %h want %h<-%h be f",
                 i, wr_addr[i], wr_data[i], wr_be[i], 32'h1000 + 32'(4 * i), ed[i]);
      end
    end
  endtask

  task automatic test_zero_and_restart;
    @(negedge clk);
    start = 1; base_addr = 32'h500; byte_count = 16'd0;
    @(negedge clk);
    start = 0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL zero_done got done=%b busy=%b req=%b want 1 0 0", done, busy, mem_req);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL zero_after got done=%b req=%b want 0 0", done, mem_req);
    end
    for (int i = 0; i < 7; i++) src[i] = 8'(8'hC0 + i);
    run_xfer(32'h300, 7, 0, 3);
    checks++;
    if (!got_done || n_wr != 2) begin
      failures++;
      $display("FAIL restart_count got done=%0d writes=%0d want 1 2", got_done, n_wr);
    end
    checks++;
    if (wr_addr[0] !== 32'h300 || wr_data[0] !== 32'hC3C2_C1C0 || wr_be[0] !== 4'hF ||
        wr_addr[1] !== 32'h304 || wr_data[1] !== 32'h00C6_C5C4 || wr_be[1] !== 4'h7) begin
      failures++;
      $display("FAIL restart_writes got %h<-%h/%h %h<-%h/%h want 300<-c3c2c1c0/f 304<-00c6c5c4/7",
               wr_addr[0], wr_data[0], wr_be[0], wr_addr[1], wr_data[1], wr_be[1]);
    end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 8; i++) src[i] = 8'(8'hB0 + i);
    run_xfer(32'hFFFF_FFFC, 8, 0, -1);
    checks++;
    if (!got_done || n_wr != 2 ||
        wr_addr[0] !== 32'hFFFF_FFFC || wr_data[0] !== 32'hB3B2_B1B0 ||
        wr_addr[1] !== 32'h0000_0000 || wr_data[1] !== 32'hB7B6_B5B4) begin
      failures++;
      $display("FAIL wrap got n=%0d %h<-%h %h<-%h want 2 fffffffc<-b3b2b1b0 00000000<-b7b6b5b4",
               n_wr, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 12; i++) src[i] = 8'(8'h50 + i);
    @(negedge clk);
    start = 1; base_addr = 32'h400; byte_count = 16'd12; mem_gnt = 0; periph_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 0; periph_valid = 1; peripheral_data_in = src[i];
    end
    @(negedge clk);
    periph_valid = 0;
    checks++;
    if (mem_req !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pre got req=%b busy=%b want 1 1", mem_req, busy);
    end
    reset = 1;
    @(negedge clk);
    reset = 0;
    checks++;
    if ({busy, done, periph_ready, mem_req, memory_write_enable} !== 5'b0 ||
        {memory_address, memory_data_out, mem_be} !== 68'h0) begin
      failures++;
      $display("FAIL midreset_outputs got ctrl=%b addr=%h data=%h be=%h want all 0",
               {busy, done, periph_ready, mem_req, memory_write_enable},
               memory_address, memory_data_out, mem_be);
    end
    for (int i = 0; i < 8; i++) src[i] = 8'(8'h11 * (i + 1));
    run_xfer(32'h100, 8, 0, -1);
    checks++;
    if (!got_done || n_wr != 2 || gap != 1 ||
        wr_addr[0] !== 32'h100 || wr_data[0] !== 32'h4433_2211 || wr_be[0] !== 4'hF ||
        wr_addr[1] !== 32'h104 || wr_data[1] !== 32'h8877_6655 || wr_be[1] !== 4'hF) begin
      failures++;
      $display("FAIL midreset_rerun got n=%0d gap=%0d %h<-%h %h<-%h want 2 1 100<-44332211 104<-88776655",
               n_wr, gap, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
    end
  endtask

  initial begin
    test_reset;
    test_streaming;
    test_partial;
    test_grant_stall;
    test_zero_and_restart;
    test_wrap;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
